// File: rtl/pipe_reg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pipe_reg_pkg : shared defaults and count-width helper            |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package pipe_reg_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 2;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg_stage.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pipe_reg_stage : one valid+data register slot with ready logic   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module pipe_reg_stage #(
   parameter int              WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             prev_valid,
   input  logic [WIDTH-1:0] prev_data,
   input  logic             next_ready,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   assign ready = !valid || next_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         data  <= RST_VAL;
      end else if (clr) begin
         valid <= 1'b0;
      end else if (ready) begin
         valid <= prev_valid;
         // Data only moves with a valid word, so idle stages do not toggle.
         if (prev_valid) begin
            data <= prev_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pipe_reg : DEPTH-stage valid/ready register pipeline             |
// | Optional flush port enabled by macro PIPE_REG_FLUSH_EN           |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module pipe_reg
   import pipe_reg_pkg::*;
#(
   parameter int               WIDTH   = DEFAULT_WIDTH,
   parameter int               DEPTH   = DEFAULT_DEPTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                          clk,
   input  logic                          rst,
`ifdef PIPE_REG_FLUSH_EN
   input  logic                          flush,
`endif
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [count_width(DEPTH)-1:0] count
);

   localparam int CW = count_width(DEPTH);

   if (DEPTH < 1 || DEPTH > 16 || WIDTH < 1 || WIDTH > 1024) begin : g_param_err
      $error("pipe_reg: DEPTH must be 1..16 and WIDTH 1..1024");
   end

   logic             w_clr;
   logic [DEPTH-1:0] w_valid_bits;

`ifdef PIPE_REG_FLUSH_EN
   assign w_clr = flush;
`else
   assign w_clr = 1'b0;
`endif

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             w_rdy;
      logic             w_vld;
      logic [WIDTH-1:0] w_dat;
      logic             w_prev_vld;
      logic [WIDTH-1:0] w_prev_dat;
      logic             w_next_rdy;

      if (i == 0) begin : g_first
         assign w_prev_vld = in_valid;
         assign w_prev_dat = in_data;
      end else begin : g_mid
         assign w_prev_vld = g_stage[i-1].w_vld;
         assign w_prev_dat = g_stage[i-1].w_dat;
      end

      if (i == DEPTH - 1) begin : g_last
         assign w_next_rdy = out_ready;
      end else begin : g_inner
         assign w_next_rdy = g_stage[i+1].w_rdy;
      end

      assign w_valid_bits[i] = w_vld;

      pipe_reg_stage #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .clr        (w_clr),
         .prev_valid (w_prev_vld),
         .prev_data  (w_prev_dat),
         .next_ready (w_next_rdy),
         .ready      (w_rdy),
         .valid      (w_vld),
         .data       (w_dat)
      );
   end

   // Gating with rst keeps in_ready low for the whole reset assertion.
   assign in_ready  = g_stage[0].w_rdy && rst && !w_clr;
   assign out_valid = g_stage[DEPTH-1].w_vld && !w_clr;
   assign out_data  = g_stage[DEPTH-1].w_dat;

   always_comb begin
      count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count = count + CW'(w_valid_bits[i]);
      end
   end

endmodule
`default_nettype wire
